dmem_arbiter: RTL

Two-port arbiter and access sequencer in front of the single-port, word-addressed `data_memory`. It shares the memory between the CPU load/store port (m0) and the loader/DMA port (m1) with round-robin priority. It returns read data and write acknowledges to the owning requester. Partial-word stores are converted into a read-modify-write sequence, because the memory commits whole words.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_byte_merge.sv | 14 +
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State MERGE is only reachable when DMEM_ARB_RMW_EN is defined.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    localparam logic [3:0] WMASK_FULL = 4'hF;
    localparam logic [3:0] WMASK_NONE = 4'h0;

endpackage

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: lanes with mask=1 come from new_word,
// the rest from old_word. Used by the read-modify-write path.
module dmem_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  mask,
    output logic [31:0] merged
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter in front of the single-port data memory.
// Define DMEM_ARB_RMW_EN to turn partial-word stores into read-modify-write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [3:0]            m0_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rsp_valid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [3:0]            m1_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rsp_valid,
    output logic [31:0]           m1_rdata,
    output logic                  mem_we,
    output logic [3:0]            mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    arb_state_e            state;
    master_id_e            rr_last;
    master_id_e            owner_p1;
    master_id_e            gnt_id;
    logic                  vld_p1;
    logic                  gnt_any;
    logic                  pick_m1;
    logic                  g_we;
    logic [3:0]            g_wmask;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [31:0]           g_wdata;

    // Grant is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        if (m0_req && m1_req) pick_m1 = (rr_last == M0);
        else                  pick_m1 = m1_req;
        gnt_any = rst_n && (state == IDLE) && (m0_req || m1_req);
        gnt_id  = pick_m1 ? M1 : M0;
        g_we    = pick_m1 ? m1_we    : m0_we;
        g_wmask = pick_m1 ? m1_wmask : m0_wmask;
        g_addr  = pick_m1 ? m1_addr  : m0_addr;
        g_wdata = pick_m1 ? m1_wdata : m0_wdata;
    end

    assign m0_gnt = gnt_any && !pick_m1;
    assign m1_gnt = gnt_any &&  pick_m1;

`ifdef DMEM_ARB_RMW_EN
    logic                  g_partial;
    logic [ADDR_WIDTH-1:0] rmw_addr_p1;
    logic [31:0]           rmw_wdata_p1;
    logic [3:0]            rmw_wmask_p1;
    logic [31:0]           merged_wdata;

    assign g_partial = g_we && (g_wmask != WMASK_FULL) && (g_wmask != WMASK_NONE);

    dmem_byte_merge u_merge (
        .old_word (mem_rdata),
        .new_word (rmw_wdata_p1),
        .mask     (rmw_wmask_p1),
        .merged   (merged_wdata)
    );

    // Grant -> MERGE: hold the partial store while the old word is read
    always_ff @(posedge clk) begin
        if (gnt_any && g_partial) begin
            rmw_addr_p1  <= g_addr;
            rmw_wdata_p1 <= g_wdata;
            rmw_wmask_p1 <= g_wmask;
        end
    end
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_wmask = WMASK_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef DMEM_ARB_RMW_EN
        if (state == MERGE) begin
            mem_we    = 1'b1;
            mem_wmask = WMASK_FULL;
            mem_addr  = rmw_addr_p1;
            mem_wdata = merged_wdata;
        end else if (gnt_any) begin
            mem_addr = g_addr;
            if (g_we && (g_wmask == WMASK_FULL)) begin
                mem_we    = 1'b1;
                mem_wmask = WMASK_FULL;
                mem_wdata = g_wdata;
            end
        end
`else
        if (gnt_any) begin
            mem_addr = g_addr;
            if (g_we && (g_wmask != WMASK_NONE)) begin
                mem_we    = 1'b1;
                mem_wmask = g_wmask;
                mem_wdata = g_wdata;
            end
        end
`endif
    end

    // Grant -> response: owner and valid registered one cycle after the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= M1;
            vld_p1   <= 1'b0;
            owner_p1 <= M0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rr_last  <= gnt_id;
                        owner_p1 <= gnt_id;
`ifdef DMEM_ARB_RMW_EN
                        if (g_partial) state  <= MERGE;
                        else           vld_p1 <= 1'b1;
`else
                        vld_p1 <= 1'b1;
`endif
                    end
                end
                MERGE: begin
                    vld_p1 <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign m0_rsp_valid = vld_p1 && (owner_p1 == M0);
    assign m1_rsp_valid = vld_p1 && (owner_p1 == M1);
    assign m0_rdata     = mem_rdata;
    assign m1_rdata     = mem_rdata;

endmodule
